phase_search_ctrl: RTL
======================

// Module: phase_search_ctrl
// PURPOSE
//  Automatic RX sampling-phase controller for the PRBS9/BPSK/RC link.
//  Sweeps the RX sample offset over all OS phases; per phase it settles, clears the BER counters and measures one window.
//  Locks onto the phase with the fewest errors, then monitors BER and re-searches on lock loss.
//  Placed between the switch/VIO control and the RX buffer mux + ber block; it drives the offset in place of sw[3:2].
// PARAMETERS
//  OS         4    oversampling factor = number of candidate phases
//  NB_OFFSET  2    offset width, clog2(OS)
//  NB_COUNT   64   width of BER error/bit counters
//  WINDOW     511  bits per measurement window (i_bits threshold)
//  SETTLE     16   valid strobes waited after an offset change
//  TIMEOUT    2044 valid strobes allowed per window before abort
//  LOCK_THR   0    max errors per window accepted as locked
// PORTS
//  clock          in   1          system clock
//  i_reset        in   1          async reset, active-low
//  i_enable       in   1          run search/monitor; low -> IDLE
//  i_valid        in   1          baud strobe (1 cycle every OS clocks)
//  i_restart      in   1          1-cycle pulse: force a new sweep
//  i_errors       in   NB_COUNT   error count from ber
//  i_bits         in   NB_COUNT   bit count from ber
//  o_offset       out  NB_OFFSET  RX sample offset to the buffer mux
//  o_ber_clear    out  1          1-cycle active-high clear to ber
//  o_locked       out  1          high while in LOCKED
//  o_searching    out  1          high in SETTLE/CLEAR/MEASURE/EVAL
//  o_best_errors  out  NB_COUNT   lowest error count of last sweep
//  o_state        out  3          state code, debug/VIO
// BEHAVIOUR
//  Reset (i_reset=0, async): state IDLE, o_offset=0, o_ber_clear=0, o_locked=0, o_searching=0, o_best_errors=all-ones,
//   trial=0, counters=0. All outputs registered.
//  States: IDLE=0 SETTLE=1 CLEAR=2 MEASURE=3 EVAL=4 LOCKED=5.
//  IDLE: i_enable=1 -> SETTLE with trial=0, o_offset=0, best=all-ones, best_off=0.
//  SETTLE: count i_valid strobes; on the SETTLE-th strobe -> CLEAR.
//  CLEAR: o_ber_clear=1 for exactly this cycle; strobe counter zeroed; -> MEASURE.
//  MEASURE: count i_valid strobes. i_bits>=WINDOW -> EVAL with err=i_errors;
//   else strobe count reaches TIMEOUT -> EVAL with err=all-ones (rx disabled/no sync).
//  EVAL (1 cycle): if err<best (strict; ties keep lower offset) then best<=err, best_off<=trial.
//   If trial<OS-1: trial++, o_offset<=trial+1 -> SETTLE.
//   Else o_best_errors<=final best; final best<=LOCK_THR -> o_offset<=best_off, LOCKED (via clear pulse);
//   else restart sweep at trial=0 (SETTLE, best reset to all-ones).
//  LOCKED: on entry, and after each window, o_ber_clear pulses 1 cycle; at i_bits>=WINDOW:
//   i_errors<=LOCK_THR -> stay; else lock lost -> SETTLE, trial=0, best reset. TIMEOUT in LOCKED also = lock lost.
//  o_offset changes only on EVAL exit / sweep restart; it is stable for a whole trial.
//  Counters are wide enough for TIMEOUT; they never wrap (they saturate/clear on state exit).
//  Priority per cycle: reset > i_enable=0 (-> IDLE next cycle, o_offset held, o_locked=0)
//   > i_restart (from any non-IDLE state -> SETTLE, trial=0) > normal transitions.
//  i_restart while in IDLE is ignored. i_valid is ignored in CLEAR and EVAL.
//  Sweep latency with healthy RX ~ OS*(SETTLE+WINDOW+ber latency) strobes.
// TESTING
//  1. Reset mid-MEASURE -> next cycle state=0, o_offset=0, o_best_errors=all-ones, o_ber_clear=0.
//  2. Model errors per offset {40,0,7,90}, LOCK_THR=0 -> 4 clear pulses, locks with o_offset=1, o_best_errors=0.
//  3. Errors {5,5,5,5}, LOCK_THR=5 -> ties resolve to o_offset=0, o_locked=1.
//  4. Errors all 3, LOCK_THR=0 -> no lock, sweep repeats from offset 0, o_locked stays 0.
//  5. i_bits frozen at 0 -> each trial times out after 2044 strobes; sweep restarts; o_best_errors=all-ones.
//  6. Locked at offset 2, then window with 1 error -> SETTLE at offset 0; i_restart with i_enable=0 -> IDLE.

Source files
------------

// File: rtl/phase_search_ctrl.sv
// rtl/phase_search_ctrl.sv - RX sampling-phase sweep, lock and BER monitor controller
module phase_search_ctrl #(
  parameter int OS        = 4,
  parameter int NB_OFFSET = 2,
  parameter int NB_COUNT  = 64,
  parameter int WINDOW    = 511,
  parameter int SETTLE    = 16,
  parameter int TIMEOUT   = 2044,
  parameter int LOCK_THR  = 0
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic                 i_restart,
  input  logic [NB_COUNT-1:0]  i_errors,
  input  logic [NB_COUNT-1:0]  i_bits,
  output logic [NB_OFFSET-1:0] o_offset,
  output logic                 o_ber_clear,
  output logic                 o_locked,
  output logic                 o_searching,
  output logic [NB_COUNT-1:0]  o_best_errors,
  output logic [2:0]           o_state
);

  localparam int NB_CNT = $clog2(TIMEOUT + 1);
  localparam logic [NB_COUNT-1:0]  ALL_ONES  = {NB_COUNT{1'b1}};
  localparam logic [NB_COUNT-1:0]  WIN       = NB_COUNT'(WINDOW);
  localparam logic [NB_COUNT-1:0]  THR       = NB_COUNT'(LOCK_THR);
  localparam logic [NB_CNT-1:0]    SET_LAST  = NB_CNT'(SETTLE - 1);
  localparam logic [NB_CNT-1:0]    TO_LAST   = NB_CNT'(TIMEOUT - 1);
  localparam logic [NB_OFFSET-1:0] LAST_TRY  = NB_OFFSET'(OS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SETTLE = 3'd1, S_CLEAR = 3'd2,
    S_MEASURE = 3'd3, S_EVAL = 3'd4, S_LOCKED = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_OFFSET-1:0] trial_q, trial_d, offset_q, offset_d, best_off_q, best_off_d;
  logic [NB_COUNT-1:0] best_q, best_d, err_q, err_d, best_out_q, best_out_d;
  logic                clr_q, clr_d, locked_q, searching_q;
  logic                start_sweep;
  logic [NB_COUNT-1:0] cand_err;
  logic [NB_OFFSET-1:0] cand_off;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trial_d     = trial_q;
    offset_d    = offset_q;
    best_d      = best_q;
    best_off_d  = best_off_q;
    best_out_d  = best_out_q;
    err_d       = err_q;
    clr_d       = 1'b0;
    start_sweep = 1'b0;
    cand_err    = (err_q < best_q) ? err_q : best_q;
    cand_off    = (err_q < best_q) ? trial_q : best_off_q;

    case (state_q)
      S_IDLE: if (i_enable) start_sweep = 1'b1;
      S_SETTLE: begin
        if (i_valid) begin
          if (cnt_q == SET_LAST) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (i_bits >= WIN) begin
          err_d   = i_errors;
          state_d = S_EVAL;
        end else if (i_valid) begin
          if (cnt_q == TO_LAST) begin
            err_d   = ALL_ONES;
            state_d = S_EVAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_EVAL: begin
        cnt_d = '0;
        if (trial_q < LAST_TRY) begin
          best_d     = cand_err;
          best_off_d = cand_off;
          trial_d    = trial_q + 1'b1;
          offset_d   = trial_q + 1'b1;
          state_d    = S_SETTLE;
        end else begin
          best_out_d = cand_err;
          if (cand_err <= THR) begin
            best_d     = cand_err;
            best_off_d = cand_off;
            offset_d   = cand_off;
            clr_d      = 1'b1;
            state_d    = S_LOCKED;
          end else begin
            start_sweep = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        // The cycle the clear pulse is out, i_bits still holds the previous window.
        if (!clr_q && (i_bits >= WIN)) begin
          if (i_errors <= THR) begin
            clr_d = 1'b1;
            cnt_d = '0;
          end else begin
            start_sweep = 1'b1;
          end
        end else if (i_valid) begin
          if (cnt_q == TO_LAST) start_sweep = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_sweep || (i_restart && state_q != S_IDLE)) begin
      state_d    = S_SETTLE;
      trial_d    = '0;
      offset_d   = '0;
      best_d     = ALL_ONES;
      best_off_d = '0;
      cnt_d      = '0;
      clr_d      = 1'b0;
    end

    if (!i_enable) begin
      state_d  = S_IDLE;
      offset_d = offset_q;
      cnt_d    = '0;
      clr_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      trial_q     <= '0;
      offset_q    <= '0;
      best_q      <= ALL_ONES;
      best_off_q  <= '0;
      best_out_q  <= ALL_ONES;
      err_q       <= '0;
      clr_q       <= 1'b0;
      locked_q    <= 1'b0;
      searching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trial_q     <= trial_d;
      offset_q    <= offset_d;
      best_q      <= best_d;
      best_off_q  <= best_off_d;
      best_out_q  <= best_out_d;
      err_q       <= err_d;
      clr_q       <= clr_d || (state_d == S_CLEAR);
      locked_q    <= (state_d == S_LOCKED);
      searching_q <= (state_d == S_SETTLE) || (state_d == S_CLEAR) ||
                     (state_d == S_MEASURE) || (state_d == S_EVAL);
    end
  end

  assign o_offset      = offset_q;
  assign o_ber_clear   = clr_q;
  assign o_locked      = locked_q;
  assign o_searching   = searching_q;
  assign o_best_errors = best_out_q;
  assign o_state       = state_q;

endmodule
